// File: rtl/puf_eval_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// puf_eval_sequencer_pkg
// Shared definitions for the PUF evaluation sequencer:
//   - state_t : FSM state encoding used by puf_eval_sequencer
//   - clog2   : constant-evaluable ceiling log2 used to size the nibble
//               pointer, the evaluation index and the timeout counter
// ---------------------------------------------------------------------------
package puf_eval_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_EVAL,
        ST_CAPT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Never returns less than 1 so that a value of 1 or 2 still yields a
    // usable one-bit vector.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/puf_eval_sequencer_btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings an asynchronous button into the clock domain through a two-flop
// synchronizer and turns each rising edge into a registered one-cycle pulse.
// The pulse appears on the third clock edge after the pin goes high.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-high reset
//   din    in  raw asynchronous button level
//   pulse  out one-cycle pulse per rising edge of din
// ---------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two synchronizer stages, a delayed copy for edge detection, and the
    // edge pulse itself registered so it is glitch-free for the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/puf_eval_sequencer.sv
// ---------------------------------------------------------------------------
// puf_eval_sequencer
// Loads a challenge from switches one nibble at a time, then runs RESP_BITS
// back-to-back evaluations of an external PUF core, using challenge
// (base ^ eval_index) for each, and assembles the response bits into one word
// (first evaluation in the MSB). Each evaluation has its own timeout.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   sw             switch nibble (asynchronous)
//   btn_load       write sw into the nibble at nib_ptr (IDLE only)
//   btn_run        start a run (from IDLE, DONE or ERR)
//   btn_stop       abort a run in progress
//   puf_challenge  challenge driven to the PUF core (shows base in IDLE)
//   puf_enable     replicated enable to the PUF core, all-ones in EVAL
//   puf_reset      one-cycle counter clear to the PUF core, high in ARM
//   puf_done       PUF finished (level, asynchronous)
//   puf_bit        PUF response bit, valid while puf_done is high
//   response       assembled response word
//   resp_valid     response holds a completed run
//   busy           run in progress (ARM, EVAL, CAPT, GAP)
//   err_timeout    sticky flag, last run timed out
//   nib_ptr        index of the next nibble to load
// ---------------------------------------------------------------------------
module puf_eval_sequencer
    import puf_eval_sequencer_pkg::*;
#(
    parameter int CHAL_W    = 10,
    parameter int NIB_W     = 4,
    parameter int N_CH      = 64,
    parameter int RESP_BITS = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NIB_W-1:0]     sw,
    input  logic                 btn_load,
    input  logic                 btn_run,
    input  logic                 btn_stop,
    output logic [CHAL_W-1:0]    puf_challenge,
    output logic [N_CH-1:0]      puf_enable,
    output logic                 puf_reset,
    input  logic                 puf_done,
    input  logic                 puf_bit,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_valid,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [clog2((CHAL_W + NIB_W - 1) / NIB_W)-1:0] nib_ptr
);

    localparam int NCH   = (CHAL_W + NIB_W - 1) / NIB_W;
    localparam int NP_W  = clog2(NCH);
    localparam int EXT_W = NCH * NIB_W;
    // idx must be able to hold RESP_BITS itself, the value that ends a run.
    localparam int IDX_W = clog2(RESP_BITS + 1);
    localparam int TW    = clog2(TIMEOUT);

    state_t             state;
    logic [CHAL_W-1:0]  base;
    logic [IDX_W-1:0]   idx;
    logic [TW-1:0]      tcnt;

    logic [NIB_W-1:0]   sw_meta;
    logic [NIB_W-1:0]   sw_s;
    logic               done_meta;
    logic               done_s;
    logic               bit_meta;
    logic               bit_s;

    logic               load_p;
    logic               run_p;
    logic               stop_p;

    logic [EXT_W-1:0]   load_ext;
    logic [CHAL_W-1:0]  base_loaded;
    logic               busy_state;
    logic               run_ok;

    btn_sync_edge u_sync_load (
        .clock (clock),
        .reset (reset),
        .din   (btn_load),
        .pulse (load_p)
    );

    btn_sync_edge u_sync_run (
        .clock (clock),
        .reset (reset),
        .din   (btn_run),
        .pulse (run_p)
    );

    btn_sync_edge u_sync_stop (
        .clock (clock),
        .reset (reset),
        .din   (btn_stop),
        .pulse (stop_p)
    );

    // Level synchronizers for the switches and the PUF handshake. puf_bit
    // travels through the same depth as puf_done so the bit seen with the
    // synced done is the one the core presented alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta   <= '0;
            sw_s      <= '0;
            done_meta <= 1'b0;
            done_s    <= 1'b0;
            bit_meta  <= 1'b0;
            bit_s     <= 1'b0;
        end else begin
            sw_meta   <= sw;
            sw_s      <= sw_meta;
            done_meta <= puf_done;
            done_s    <= done_meta;
            bit_meta  <= puf_bit;
            bit_s     <= bit_meta;
        end
    end

    // Candidate base after a nibble write. The base is widened to a whole
    // number of nibbles so the last nibble can be written uniformly; the
    // bits above CHAL_W are then dropped.
    always_comb begin
        load_ext              = '0;
        load_ext[CHAL_W-1:0]  = base;
        for (int n = 0; n < NCH; n++) begin
            if (nib_ptr == NP_W'(n)) begin
                load_ext[n*NIB_W +: NIB_W] = sw_s;
            end
        end
        base_loaded = load_ext[CHAL_W-1:0];
    end

    assign busy_state = (state == ST_ARM) || (state == ST_EVAL) ||
                        (state == ST_CAPT) || (state == ST_GAP);
    assign run_ok     = (state == ST_IDLE) || (state == ST_DONE) ||
                        (state == ST_ERR);

    // Main sequencer. Stop beats run, and run beats load, so a load pulse
    // is only looked at inside IDLE when neither of the others is active.
    // All PUF-facing outputs are registered; the asynchronous reset clears
    // puf_enable without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            base          <= '0;
            nib_ptr       <= '0;
            idx           <= '0;
            tcnt          <= '0;
            puf_challenge <= '0;
            puf_enable    <= '0;
            puf_reset     <= 1'b0;
            response      <= '0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            puf_reset <= 1'b0;
            if (stop_p && busy_state) begin
                state      <= ST_IDLE;
                puf_enable <= '0;
                resp_valid <= 1'b0;
                busy       <= 1'b0;
            end else if (run_p && run_ok) begin
                state         <= ST_ARM;
                idx           <= '0;
                resp_valid    <= 1'b0;
                err_timeout   <= 1'b0;
                puf_reset     <= 1'b1;
                puf_challenge <= base;
                puf_enable    <= '0;
                busy          <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_p) begin
                            base          <= base_loaded;
                            puf_challenge <= base_loaded;
                            nib_ptr       <= (nib_ptr == NP_W'(NCH - 1)) ? '0
                                                                           : nib_ptr + 1'b1;
                        end else begin
                            puf_challenge <= base;
                        end
                    end
                    ST_ARM: begin
                        state      <= ST_EVAL;
                        puf_enable <= '1;
                        tcnt       <= '0;
                    end
                    ST_EVAL: begin
                        if (done_s) begin
                            state      <= ST_CAPT;
                            response   <= {response[RESP_BITS-2:0], bit_s};
                            puf_enable <= '0;
                            idx        <= idx + 1'b1;
                        end else if (tcnt == TW'(TIMEOUT - 1)) begin
                            state       <= ST_ERR;
                            puf_enable  <= '0;
                            err_timeout <= 1'b1;
                            resp_valid  <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    ST_CAPT: begin
                        state <= ST_GAP;
                    end
                    ST_GAP: begin
                        // Wait for the core to release done before the next
                        // evaluation so one done level is never counted twice.
                        if (!done_s) begin
                            if (idx < IDX_W'(RESP_BITS)) begin
                                state         <= ST_ARM;
                                puf_reset     <= 1'b1;
                                puf_challenge <= base ^ CHAL_W'(idx);
                            end else begin
                                state      <= ST_DONE;
                                resp_valid <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    ST_ERR: begin
                        state <= ST_ERR;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_puf_eval_sequencer
// Directed bench for puf_eval_sequencer with a small PUF core model that
// answers 20 enabled cycles after enable rises, with bit = evaluation
// count [0]. Parameters reduced to RESP_BITS=4, TIMEOUT=64.
// ---------------------------------------------------------------------------
module tb_puf_eval_sequencer;

    localparam int CHAL_W    = 10;
    localparam int NIB_W     = 4;
    localparam int N_CH      = 64;
    localparam int RESP_BITS = 4;
    localparam int TIMEOUT   = 64;

    logic                 clock;
    logic                 reset;
    logic [NIB_W-1:0]     sw;
    logic                 btn_load;
    logic                 btn_run;
    logic                 btn_stop;
    logic [CHAL_W-1:0]    puf_challenge;
    logic [N_CH-1:0]      puf_enable;
    logic                 puf_reset;
    logic                 puf_done;
    logic                 puf_bit;
    logic [RESP_BITS-1:0] response;
    logic                 resp_valid;
    logic                 busy;
    logic                 err_timeout;
    logic [1:0]           nib_ptr;

    int total;
    int bad;

    // PUF model controls and observation counters
    logic                 clr_model;
    logic                 respond;
    int                   m_cnt;
    int                   ev_cnt;
    int                   en_cnt;
    int                   rst_cnt;
    logic [CHAL_W-1:0]    chal_log [8];

    puf_eval_sequencer #(
        .CHAL_W    (CHAL_W),
        .NIB_W     (NIB_W),
        .N_CH      (N_CH),
        .RESP_BITS (RESP_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sw            (sw),
        .btn_load      (btn_load),
        .btn_run       (btn_run),
        .btn_stop      (btn_stop),
        .puf_challenge (puf_challenge),
        .puf_enable    (puf_enable),
        .puf_reset     (puf_reset),
        .puf_done      (puf_done),
        .puf_bit       (puf_bit),
        .response      (response),
        .resp_valid    (resp_valid),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .nib_ptr       (nib_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // PUF core model plus a monitor that logs the challenge at each
    // puf_reset pulse and counts enabled cycles.
    always @(posedge clock or posedge reset) begin
        if (reset || clr_model) begin
            m_cnt    <= 0;
            ev_cnt   <= 0;
            en_cnt   <= 0;
            rst_cnt  <= 0;
            puf_done <= 1'b0;
            puf_bit  <= 1'b0;
        end else begin
            if (puf_reset) begin
                if (rst_cnt < 8) chal_log[rst_cnt] <= puf_challenge;
                rst_cnt <= rst_cnt + 1;
            end
            if (puf_enable == {N_CH{1'b1}}) begin
                en_cnt <= en_cnt + 1;
                if (!puf_done) begin
                    if (respond && m_cnt == 19) begin
                        puf_done <= 1'b1;
                        puf_bit  <= ev_cnt[0];
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end else begin
                if (puf_done) ev_cnt <= ev_cnt + 1;
                puf_done <= 1'b0;
                m_cnt    <= 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Hold the selected buttons for four cycles, long enough for the pulse
    // to be generated and acted on; returns right after the FSM reacted.
    task automatic press(input logic do_load, input logic do_run, input logic do_stop);
        @(negedge clock);
        btn_load = do_load;
        btn_run  = do_run;
        btn_stop = do_stop;
        repeat (4) @(negedge clock);
        btn_load = 1'b0;
        btn_run  = 1'b0;
        btn_stop = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic clear_model();
        @(negedge clock);
        clr_model = 1'b1;
        @(negedge clock);
        clr_model = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({puf_challenge, puf_enable, puf_reset, response, resp_valid, busy, err_timeout, nib_ptr} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {puf_challenge, puf_enable, puf_reset, response, resp_valid, busy, err_timeout, nib_ptr});
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({puf_challenge, busy, nib_ptr, puf_enable} !== '0) begin
            bad++;
            $display("[TB] FAIL after_reset_idle got=%h want=0", {puf_challenge, busy, nib_ptr, puf_enable});
        end
    endtask

    task automatic test_load();
        logic [3:0] vals [3];
        logic [1:0] exp_ptr [3];
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'h3;
        exp_ptr[0] = 2'd1; exp_ptr[1] = 2'd2; exp_ptr[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            sw = vals[i];
            repeat (3) @(negedge clock);
            press(1'b1, 1'b0, 1'b0);
            repeat (2) @(negedge clock);
            total++;
            if (nib_ptr !== exp_ptr[i]) begin
                bad++;
                $display("[TB] FAIL load_nib_ptr_%0d got=%0d want=%0d", i, nib_ptr, exp_ptr[i]);
            end
        end
        total++;
        if (puf_challenge !== 10'h35A) begin
            bad++;
            $display("[TB] FAIL load_base got=%h want=35a", puf_challenge);
        end
    endtask

    task automatic test_run_pattern();
        pulse_reset();
        clear_model();
        respond = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        total++;
        if (busy !== 1'b1 || puf_enable !== {N_CH{1'b1}}) begin
            bad++;
            $display("[TB] FAIL run_first_eval got=busy%b en%h want=busy1 en_all_ones", busy, puf_enable);
        end
        for (int i = 0; i < 400 && resp_valid !== 1'b1; i++) @(negedge clock);
        total++;
        if (resp_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_complete got=valid%b busy%b want=valid1 busy0", resp_valid, busy);
        end
        total++;
        if (response !== 4'b0101) begin
            bad++;
            $display("[TB] FAIL run_response got=%b want=0101", response);
        end
        total++;
        if (rst_cnt !== 4) begin
            bad++;
            $display("[TB] FAIL run_reset_pulses got=%0d want=4", rst_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (chal_log[i] !== CHAL_W'(i)) begin
                bad++;
                $display("[TB] FAIL run_challenge_%0d got=%h want=%h", i, chal_log[i], CHAL_W'(i));
            end
        end
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_no_timeout got=%b want=0", err_timeout);
        end
    endtask

    task automatic test_timeout();
        clear_model();
        respond = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clock);
        total++;
        if (err_timeout !== 1'b1 || puf_enable !== '0 || resp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_err got=err%b en%h valid%b want=err1 en0 valid0",
                     err_timeout, puf_enable, resp_valid);
        end
        total++;
        if (en_cnt !== TIMEOUT) begin
            bad++;
            $display("[TB] FAIL timeout_eval_cycles got=%0d want=%0d", en_cnt, TIMEOUT);
        end
        total++;
        if (response !== 4'b0101) begin
            bad++;
            $display("[TB] FAIL timeout_response_frozen got=%b want=0101", response);
        end
        clear_model();
        respond = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        @(negedge clock);
        total++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rerun_clears_err got=err%b busy%b want=err0 busy1", err_timeout, busy);
        end
        for (int i = 0; i < 400 && resp_valid !== 1'b1; i++) @(negedge clock);
        total++;
        if (resp_valid !== 1'b1 || response !== 4'b0101) begin
            bad++;
            $display("[TB] FAIL rerun_response got=valid%b resp%b want=valid1 resp0101", resp_valid, response);
        end
    endtask

    task automatic test_stop();
        clear_model();
        respond = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !(rst_cnt == 2 && puf_enable == {N_CH{1'b1}}); i++) @(negedge clock);
        total++;
        if (rst_cnt !== 2 || puf_enable !== {N_CH{1'b1}}) begin
            bad++;
            $display("[TB] FAIL stop_reach_eval2 got=rst%0d en%h want=rst2 en_all_ones", rst_cnt, puf_enable);
        end
        press(1'b0, 1'b0, 1'b1);
        total++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || puf_enable !== '0) begin
            bad++;
            $display("[TB] FAIL stop_to_idle got=busy%b valid%b en%h want=busy0 valid0 en0",
                     busy, resp_valid, puf_enable);
        end
        total++;
        if (response !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL stop_response_kept got=%b want=1010", response);
        end
        sw = 4'h7;
        repeat (3) @(negedge clock);
        press(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        total++;
        if (nib_ptr !== 2'd1 || puf_challenge !== 10'h007) begin
            bad++;
            $display("[TB] FAIL stop_then_load got=ptr%0d chal%h want=ptr1 chal007", nib_ptr, puf_challenge);
        end
    endtask

    task automatic test_simultaneous();
        respond = 1'b0;
        sw = 4'h9;
        repeat (3) @(negedge clock);
        press(1'b1, 1'b1, 1'b0);
        total++;
        if (busy !== 1'b1 || nib_ptr !== 2'd1) begin
            bad++;
            $display("[TB] FAIL run_beats_load got=busy%b ptr%0d want=busy1 ptr1", busy, nib_ptr);
        end
        repeat (3) @(negedge clock);
        press(1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        total++;
        if (busy !== 1'b0 || puf_enable !== '0 || puf_challenge !== 10'h007) begin
            bad++;
            $display("[TB] FAIL stop_beats_run got=busy%b en%h chal%h want=busy0 en0 chal007",
                     busy, puf_enable, puf_challenge);
        end
    endtask

    task automatic test_async_reset();
        respond = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        total++;
        if (puf_enable !== {N_CH{1'b1}}) begin
            bad++;
            $display("[TB] FAIL async_pre_eval got=%h want=all_ones", puf_enable);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({puf_challenge, puf_enable, puf_reset, response, resp_valid, busy, err_timeout, nib_ptr} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset_outputs got=%h want=0",
                     {puf_challenge, puf_enable, puf_reset, response, resp_valid, busy, err_timeout, nib_ptr});
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        sw        = '0;
        btn_load  = 1'b0;
        btn_run   = 1'b0;
        btn_stop  = 1'b0;
        clr_model = 1'b0;
        respond   = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_load();
        test_run_pattern();
        test_timeout();
        test_stop();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
